// File: rtl/rx_phase_sync.sv
// rx_phase_sync: symbol-timing acquisition for the RX matched filter.
// Accumulates |rx_in| per sampling phase over 2^WIN_LOG2 symbols, then
// picks the phase with the largest energy and drives it to the filter.
module rx_phase_sync #(
   parameter int unsigned UPSAMPLE   = 4,
   parameter int unsigned DATA_NBITS = 8,
   parameter int unsigned WIN_LOG2   = 10,
   localparam int unsigned PH_W      = $clog2(UPSAMPLE),
   localparam int unsigned ACC_NBITS = DATA_NBITS + WIN_LOG2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         start,
   input  logic signed [DATA_NBITS-1:0] rx_in,
   output logic [PH_W-1:0]              phase_out,
   output logic [ACC_NBITS-1:0]         energy_max,
   output logic                         busy,
   output logic                         locked,
   output logic                         done
);

   localparam logic [PH_W-1:0] PH_LAST = PH_W'(UPSAMPLE - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ALIGN  = 2'd1,
      ACCUM  = 2'd2,
      SELECT = 2'd3
   } state_t;

   state_t                  state;
   state_t                  state_nxt;

   logic [PH_W-1:0]         cnt;
   logic [ACC_NBITS-1:0]    acc [UPSAMPLE];
   logic [WIN_LOG2-1:0]     sym_cnt;
   logic [PH_W-1:0]         sel_j;
   logic [PH_W-1:0]         best;
   logic [ACC_NBITS-1:0]    best_val;

   logic [DATA_NBITS-1:0]   mag_c;
   logic                    clr_c;
   logic                    acc_en_c;
   logic                    sel_init_c;
   logic                    sel_done_c;
   logic                    sel_gt_c;

   // Magnitude of the signed sample; the most negative value maps to 2^(N-1).
   always_comb begin
      mag_c = $unsigned(rx_in);
      if (rx_in[DATA_NBITS-1]) begin
         mag_c = $unsigned(-rx_in);
      end
   end

   // Candidate comparison for the current SELECT step (strict: ties keep lower index).
   always_comb begin
      sel_gt_c = (acc[sel_j] > best_val);
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and datapath strobes.
   always_comb begin
      state_nxt  = state;
      clr_c      = 1'b0;
      acc_en_c   = 1'b0;
      sel_init_c = 1'b0;
      sel_done_c = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               clr_c     = 1'b1;
               state_nxt = ALIGN;
            end
         end
         ALIGN: begin
            if (enable && (cnt == PH_LAST)) begin
               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            if (enable) begin
               acc_en_c = 1'b1;
               if ((cnt == PH_LAST) && (sym_cnt == '1)) begin
                  sel_init_c = 1'b1;
                  state_nxt  = SELECT;
               end
            end
         end
         SELECT: begin
            if (sel_j == PH_LAST) begin
               sel_done_c = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Free-running phase counter, kept in step with the filter's own counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + PH_W'(1);
      end
   end

   // Per-phase energy accumulators and window symbol counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(UPSAMPLE); i++) begin
            acc[i] <= '0;
         end
         sym_cnt <= '0;
      end else if (clr_c) begin
         for (int i = 0; i < int'(UPSAMPLE); i++) begin
            acc[i] <= '0;
         end
         sym_cnt <= '0;
      end else if (acc_en_c) begin
         acc[cnt] <= acc[cnt] + ACC_NBITS'(mag_c);
         if (cnt == PH_LAST) begin
            sym_cnt <= sym_cnt + WIN_LOG2'(1);
         end
      end
   end

   // Sequential max search, one accumulator per clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_j    <= '0;
         best     <= '0;
         best_val <= '0;
      end else if (sel_init_c) begin
         sel_j    <= PH_W'(1);
         best     <= '0;
         best_val <= acc[0];
      end else if (state == SELECT) begin
         if (sel_gt_c) begin
            best     <= sel_j;
            best_val <= acc[sel_j];
         end
         sel_j <= sel_j + PH_W'(1);
      end
   end

   // Registered outputs; results hold until the next completed acquisition.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_out  <= '0;
         energy_max <= '0;
         busy       <= 1'b0;
         locked     <= 1'b0;
         done       <= 1'b0;
      end else begin
         busy <= (state_nxt != IDLE);
         done <= sel_done_c;
         if (sel_done_c) begin
            phase_out  <= sel_gt_c ? sel_j : best;
            energy_max <= sel_gt_c ? acc[sel_j] : best_val;
            locked     <= 1'b1;
         end
      end
   end

endmodule
